// File: rtl/fetch_pkg.sv
// Shared state encoding, reset defaults and buffer layout for the IF-stage fetch sequencer.
package fetch_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_FULL
  } state_t;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_3000;
  localparam logic [31:0] PC_STEP_DEFAULT  = 32'd4;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_buf_t;

endpackage

// File: rtl/fetch_next_pc.sv
// Next fetch PC mux: pending jump target, then live redirect, then sequential step (32-bit wrap).
// Combinational only; with FETCH_ALIGN_CHECK_EN misaligned redirect targets are word-aligned and flagged.
module fetch_next_pc
  import fetch_pkg::*;
#(
  parameter logic [31:0] PC_STEP = PC_STEP_DEFAULT
) (
  input  logic        pending_i,
  input  logic [31:0] pend_tgt_i,
  input  logic        redirect_valid_i,
  input  logic [31:0] redirect_target_i,
  input  logic [31:0] pc_i,
  output logic [31:0] tgt_o,
  output logic        misalign_o,
  output logic [31:0] next_pc_o
);

`ifdef FETCH_ALIGN_CHECK_EN
  assign tgt_o      = {redirect_target_i[31:2], 2'b00};
  assign misalign_o = |redirect_target_i[1:0];
`else
  assign tgt_o      = redirect_target_i;
  assign misalign_o = 1'b0;
`endif

  always_comb begin
    next_pc_o = pc_i + PC_STEP;
    if (pending_i) begin
      next_pc_o = pend_tgt_i;
    end else if (redirect_valid_i) begin
      next_pc_o = tgt_o;
    end
  end

endmodule

// File: rtl/fetch_sequencer.sv
// IF stage: PC register, imem req/ack handshake, IF/ID register; ack to if_valid is 1 cycle, stall parks one word.
// Redirects honour the MIPS delay slot; optional FETCH_ALIGN_CHECK_EN masks/flags misaligned targets.
module fetch_sequencer
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
  parameter logic [31:0] PC_STEP  = PC_STEP_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_target,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic        if_valid,
  output logic [31:0] if_pc,
  output logic [31:0] if_instr,
  output logic [31:0] pc,
  output logic        align_err
);

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic        pending_q, pending_d;
  logic [31:0] pend_tgt_q, pend_tgt_d;
  fetch_buf_t  ifid_q, ifid_d;
  fetch_buf_t  buf_q, buf_d;
  logic        if_valid_q, if_valid_d;
  logic        align_err_q, align_err_d;
  logic [31:0] tgt;
  logic [31:0] next_pc;
  logic        misalign;

  fetch_next_pc #(.PC_STEP(PC_STEP)) u_next_pc (
    .pending_i         (pending_q),
    .pend_tgt_i        (pend_tgt_q),
    .redirect_valid_i  (redirect_valid),
    .redirect_target_i (redirect_target),
    .pc_i              (pc_q),
    .tgt_o             (tgt),
    .misalign_o        (misalign),
    .next_pc_o         (next_pc)
  );

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    pending_d   = pending_q;
    pend_tgt_d  = pend_tgt_q;
    ifid_d      = ifid_q;
    buf_d       = buf_q;
    if_valid_d  = if_valid_q;
    align_err_d = align_err_q;
    case (state_q)
      S_IDLE: state_d = S_WAIT;
      S_WAIT: begin
        if (imem_ack) begin
          pc_d      = next_pc;
          pending_d = 1'b0;
          if (stall && if_valid_q) begin
            buf_d.pc    = pc_q;
            buf_d.instr = imem_rdata;
            state_d     = S_FULL;
          end else begin
            ifid_d.pc    = pc_q;
            ifid_d.instr = imem_rdata;
            if_valid_d   = 1'b1;
          end
        end else begin
          if (!stall) if_valid_d = 1'b0;
          // Delay slot not fetched yet: remember the target until its ack.
          if (redirect_valid) begin
            pending_d  = 1'b1;
            pend_tgt_d = tgt;
          end
        end
      end
      S_FULL: begin
        // Delay slot already sits in buf, so the jump takes effect at once.
        if (redirect_valid) pc_d = next_pc;
        if (!stall) begin
          ifid_d     = buf_q;
          if_valid_d = 1'b1;
          state_d    = S_WAIT;
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (redirect_valid && misalign) align_err_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      pc_q        <= RESET_PC;
      pending_q   <= 1'b0;
      pend_tgt_q  <= '0;
      ifid_q      <= '0;
      buf_q       <= '0;
      if_valid_q  <= 1'b0;
      align_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      pending_q   <= pending_d;
      pend_tgt_q  <= pend_tgt_d;
      ifid_q      <= ifid_d;
      buf_q       <= buf_d;
      if_valid_q  <= if_valid_d;
      align_err_q <= align_err_d;
    end
  end

  assign imem_req  = (state_q == S_WAIT);
  assign imem_addr = pc_q;
  assign if_valid  = if_valid_q;
  assign if_pc     = ifid_q.pc;
  assign if_instr  = ifid_q.instr;
  assign pc        = pc_q;
  assign align_err = align_err_q;

  a_redirect_not_pending: assert property (@(posedge clk) disable iff (reset)
    redirect_valid |-> !pending_q);
  a_redirect_if_valid: assert property (@(posedge clk) disable iff (reset)
    redirect_valid |-> if_valid_q);
  a_redirect_no_stall: assert property (@(posedge clk) disable iff (reset)
    redirect_valid |-> !stall);

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer: memory model with variable latency, scoreboards on fetches and IF/ID consumption.
module tb_fetch_sequencer;

`ifdef FETCH_ALIGN_CHECK_EN
  localparam logic [31:0] EXP_T   = 32'h0000_3100;
  localparam logic [31:0] EXP_ERR = 32'd1;
`else
  localparam logic [31:0] EXP_T   = 32'h0000_3102;
  localparam logic [31:0] EXP_ERR = 32'd0;
`endif

  logic        clk;
  logic        reset;
  logic        stall;
  logic        redirect_valid;
  logic [31:0] redirect_target;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        if_valid;
  logic [31:0] if_pc;
  logic [31:0] if_instr;
  logic [31:0] pc;
  logic        align_err;

  int passed = 0;
  int total  = 0;
  int lat    = 0;
  bit mem_en = 1'b1;

  logic [31:0] exp_fetch[$];
  logic [31:0] exp_deliv[$];
  logic [31:0] exp_seq [12];

  fetch_sequencer dut (
    .clk             (clk),
    .reset           (reset),
    .stall           (stall),
    .redirect_valid  (redirect_valid),
    .redirect_target (redirect_target),
    .imem_req        (imem_req),
    .imem_addr       (imem_addr),
    .imem_ack        (imem_ack),
    .imem_rdata      (imem_rdata),
    .if_valid        (if_valid),
    .if_pc           (if_pc),
    .if_instr        (if_instr),
    .pc              (pc),
    .align_err       (align_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], ~a[15:0]};
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got === want) passed++;
    else $display("FAIL %s: got %h want %h", name, got, want);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Instruction memory: ack after 'lat' idle cycles of a held request.
  initial begin
    int wcnt;
    wcnt = 0;
    imem_ack   = 1'b0;
    imem_rdata = '0;
    forever begin
      @(posedge clk);
      #2;
      if (mem_en && imem_req) begin
        if (wcnt >= lat) begin
          imem_ack   = 1'b1;
          imem_rdata = mem_word(imem_addr);
          wcnt       = 0;
        end else begin
          imem_ack = 1'b0;
          wcnt++;
        end
      end else begin
        imem_ack = 1'b0;
        wcnt     = 0;
      end
    end
  end

  // Monitor: acked fetches and IF/ID words consumed by ID (if_valid && !stall).
  initial begin
    logic [31:0] e;
    forever begin
      @(negedge clk);
      if (imem_req && imem_ack) begin
        if (exp_fetch.size() == 0) begin
          total++;
          $display("FAIL fetch_unexpected: got addr %h want no fetch", imem_addr);
        end else begin
          e = exp_fetch.pop_front();
          chk("fetch_addr", imem_addr, e);
        end
      end
      if (if_valid && !stall && !reset) begin
        if (exp_deliv.size() == 0) begin
          total++;
          $display("FAIL deliv_unexpected: got pc %h want no delivery", if_pc);
        end else begin
          e = exp_deliv.pop_front();
          chk("deliv_pc", if_pc, e);
          chk("deliv_instr", if_instr, mem_word(e));
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "timeout");
  end

  initial begin
    reset           = 1'b1;
    stall           = 1'b0;
    redirect_valid  = 1'b0;
    redirect_target = '0;
    exp_seq = '{32'h3000, 32'h3004, 32'h3008, 32'h300C, 32'h3100, 32'h3104,
                32'h3200, 32'h3204, 32'h3300, 32'h3000, 32'h3004, EXP_T};
    for (int i = 0; i < 12; i++) begin
      exp_fetch.push_back(exp_seq[i]);
      exp_deliv.push_back(exp_seq[i]);
    end

    repeat (2) @(posedge clk);
    #1;
    chk("rst_pc", pc, 32'h3000);
    chk("rst_req", {31'd0, imem_req}, 32'd0);
    chk("rst_if_valid", {31'd0, if_valid}, 32'd0);
    chk("rst_if_pc", if_pc, 32'd0);
    chk("rst_if_instr", if_instr, 32'd0);
    chk("rst_align_err", {31'd0, align_err}, 32'd0);
    reset = 1'b0;

    tick();
    chk("first_req", {31'd0, imem_req}, 32'd1);
    chk("first_addr", imem_addr, 32'h3000);
    tick();
    chk("first_if_valid", {31'd0, if_valid}, 32'd1);
    chk("first_if_pc", if_pc, 32'h3000);
    tick();
    stall = 1'b1;
    tick();
    chk("full_req", {31'd0, imem_req}, 32'd0);
    chk("full_hold_if_pc", if_pc, 32'h3004);
    chk("full_pc", pc, 32'h300C);
    tick();
    lat = 1;
    tick();
    stall = 1'b0;
    tick();
    chk("drain_if_pc", if_pc, 32'h3008);
    chk("drain_addr", imem_addr, 32'h300C);
    redirect_valid  = 1'b1;
    redirect_target = 32'h3100;
    tick();
    redirect_valid = 1'b0;
    chk("bubble_if_valid", {31'd0, if_valid}, 32'd0);
    tick();
    chk("pend_addr", imem_addr, 32'h3100);
    chk("delay_slot_if_pc", if_pc, 32'h300C);
    lat = 0;
    tick();
    redirect_valid  = 1'b1;
    redirect_target = 32'h3200;
    tick();
    redirect_valid = 1'b0;
    chk("same_cycle_addr", imem_addr, 32'h3200);
    tick();
    stall = 1'b1;
    tick();
    stall = 1'b0;
    chk("full2_req", {31'd0, imem_req}, 32'd0);
    redirect_valid  = 1'b1;
    redirect_target = 32'h3300;
    tick();
    redirect_valid = 1'b0;
    chk("full_redirect_addr", imem_addr, 32'h3300);
    chk("full_redirect_if_pc", if_pc, 32'h3204);
    tick();
    mem_en = 1'b0;
    tick();
    chk("stuck_req", {31'd0, imem_req}, 32'd1);
    chk("stuck_if_valid", {31'd0, if_valid}, 32'd0);
    reset = 1'b1;
    tick();
    chk("midrst_req", {31'd0, imem_req}, 32'd0);
    chk("midrst_if_valid", {31'd0, if_valid}, 32'd0);
    chk("midrst_pc", pc, 32'h3000);
    reset  = 1'b0;
    mem_en = 1'b1;
    tick();
    chk("refetch_req", {31'd0, imem_req}, 32'd1);
    chk("refetch_addr", imem_addr, 32'h3000);
    tick();
    redirect_valid  = 1'b1;
    redirect_target = 32'h3102;
    tick();
    redirect_valid = 1'b0;
    chk("align_addr", imem_addr, EXP_T);
    chk("align_err_set", {31'd0, align_err}, EXP_ERR);
    tick();
    mem_en = 1'b0;
    chk("align_err_sticky", {31'd0, align_err}, EXP_ERR);
    tick();
    tick();
    chk("fetch_q_empty", exp_fetch.size(), 32'd0);
    chk("deliv_q_empty", exp_deliv.size(), 32'd0);
    reset = 1'b1;
    tick();
    chk("align_err_cleared", {31'd0, align_err}, 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
